block_ram_queue: RTL and testbench

- Synchronous FIFO built on the existing block dual-port RAM: one write port, one read port, 1-cycle registered read latency, READ_FIRST.
- This block is the initiator and consumer of that RAM. It generates write/read addresses, tracks occupancy and absorbs the read latency with a 2-entry output skid buffer.
- Presents a first-word-fall-through valid/ready pop interface to pipeline logic (e.g. buffers between core stages and memory-side units).

---
 rtl/block_ram_queue.sv | 155 +++++++++++++++
 tb/tb_block_ram_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/block_ram_queue.sv
// block_ram_queue: FIFO over a 1-cycle-latency dual-port RAM, drained through a 2-entry skid
// buffer for a first-word-fall-through pop port. Optional macro: RSD_BLOCK_RAM_QUEUE_ERROR_FLAG_EN.
module block_ram_queue #(
  parameter int INDEX_BIT_SIZE = 2,
  parameter int ENTRY_BIT_SIZE = 4,
  parameter int ENTRY_NUM      = 1 << INDEX_BIT_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq,
  input  logic [ENTRY_BIT_SIZE-1:0] enqData,
  output logic                      full,
  output logic                      deqValid,
  input  logic                      deqReady,
  output logic [ENTRY_BIT_SIZE-1:0] deqData,
  output logic [INDEX_BIT_SIZE+1:0] count,
  output logic                      error
);

  localparam logic [INDEX_BIT_SIZE-1:0] LP_PTR_ONE  = (INDEX_BIT_SIZE)'(1);
  localparam logic [INDEX_BIT_SIZE:0]   LP_RAM_ONE  = (INDEX_BIT_SIZE+1)'(1);
  localparam logic [INDEX_BIT_SIZE:0]   LP_RAM_FULL = (INDEX_BIT_SIZE+1)'(ENTRY_NUM);
  localparam logic [INDEX_BIT_SIZE+1:0] LP_CNT_ONE  = (INDEX_BIT_SIZE+2)'(1);

  logic [ENTRY_BIT_SIZE-1:0] r_mem [ENTRY_NUM];
  logic [ENTRY_BIT_SIZE-1:0] r_rd_data;
  logic [INDEX_BIT_SIZE-1:0] r_wptr;
  logic [INDEX_BIT_SIZE-1:0] r_rptr;
  logic [INDEX_BIT_SIZE:0]   r_ram_count;
  logic                      r_rd_pending;
  logic [ENTRY_BIT_SIZE-1:0] r_skid0;
  logic [ENTRY_BIT_SIZE-1:0] r_skid1;
  logic [1:0]                r_skid_count;
  logic                      r_full;
  logic                      r_deq_valid;
  logic [INDEX_BIT_SIZE+1:0] r_count;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_issue;
  logic [2:0]                w_occ;
  logic [INDEX_BIT_SIZE:0]   w_ram_count_next;
  logic [INDEX_BIT_SIZE+1:0] w_count_next;
  logic [1:0]                w_skid_after_pop;
  logic [1:0]                w_skid_count_next;
  logic [ENTRY_BIT_SIZE-1:0] w_skid0_next;
  logic [ENTRY_BIT_SIZE-1:0] w_skid1_next;

  // Handshake, read-issue decision and next-state arithmetic.
  always_comb begin
    w_push  = enq && !r_full;
    w_pop   = r_deq_valid && deqReady;
    w_occ   = {1'b0, r_skid_count} + {2'b00, r_rd_pending};
    // Issue only if the returning word will find a free skid slot after this cycle's pop.
    w_issue = (r_ram_count != '0) && (w_occ < (w_pop ? 3'd3 : 3'd2));

    case ({w_push, w_issue})
      2'b10:   w_ram_count_next = r_ram_count + LP_RAM_ONE;
      2'b01:   w_ram_count_next = r_ram_count - LP_RAM_ONE;
      default: w_ram_count_next = r_ram_count;
    endcase

    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + LP_CNT_ONE;
      2'b01:   w_count_next = r_count - LP_CNT_ONE;
      default: w_count_next = r_count;
    endcase

    w_skid0_next     = r_skid0;
    w_skid1_next     = r_skid1;
    w_skid_after_pop = r_skid_count;
    if (w_pop) begin
      w_skid0_next     = r_skid1;
      w_skid_after_pop = r_skid_count - 2'd1;
    end else begin
      w_skid_after_pop = r_skid_count;
    end

    if (r_rd_pending) begin
      if (w_skid_after_pop == 2'd0) begin
        w_skid0_next = r_rd_data;
      end else begin
        w_skid1_next = r_rd_data;
      end
      w_skid_count_next = w_skid_after_pop + 2'd1;
    end else begin
      w_skid_count_next = w_skid_after_pop;
    end
  end

  // RAM array with registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= enqData;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[r_rptr];
    end
  end

  // Queue control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ram_count  <= '0;
      r_rd_pending <= 1'b0;
      r_skid0      <= '0;
      r_skid1      <= '0;
      r_skid_count <= 2'd0;
      r_full       <= 1'b0;
      r_deq_valid  <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LP_PTR_ONE;
      end
      if (w_issue) begin
        r_rptr <= r_rptr + LP_PTR_ONE;
      end
      r_ram_count  <= w_ram_count_next;
      r_rd_pending <= w_issue;
      r_skid0      <= w_skid0_next;
      r_skid1      <= w_skid1_next;
      r_skid_count <= w_skid_count_next;
      // full is computed from next-state only, so deqReady never reaches it combinationally.
      r_full       <= (w_ram_count_next == LP_RAM_FULL);
      r_deq_valid  <= (w_skid_count_next != 2'd0);
      r_count      <= w_count_next;
    end
  end

`ifdef RSD_BLOCK_RAM_QUEUE_ERROR_FLAG_EN
  logic r_error;

  // Sticky flag for push-while-full or pop-while-empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if ((enq && r_full) || (deqReady && !r_deq_valid)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign full     = r_full;
  assign deqValid = r_deq_valid;
  assign deqData  = r_skid0;
  assign count    = r_count;

endmodule

// File: tb/tb_block_ram_queue.sv
// Directed bench for block_ram_queue: a per-cycle vector table plus hand sequences for
// streaming, wrap-around and the sticky error flag.
module tb_block_ram_queue;

  logic       clk;
  logic       rst;
  logic       enq;
  logic [3:0] enqData;
  logic       full;
  logic       deqValid;
  logic       deqReady;
  logic [3:0] deqData;
  logic [3:0] count;
  logic       error;

  int n_checks;
  int n_errors;

  block_ram_queue #(
    .INDEX_BIT_SIZE(2),
    .ENTRY_BIT_SIZE(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enq     (enq),
    .enqData (enqData),
    .full    (full),
    .deqValid(deqValid),
    .deqReady(deqReady),
    .deqData (deqData),
    .count   (count),
    .error   (error)
  );

`ifdef RSD_BLOCK_RAM_QUEUE_ERROR_FLAG_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       enq;
    logic [3:0] data;
    logic       rdy;
    logic       exp_v;
    logic [3:0] exp_d;
    logic [3:0] exp_cnt;
    logic       exp_full;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic [3:0] d, input logic rd,
                              input logic ev, input logic [3:0] ed, input logic [3:0] ec,
                              input logic ef);
    vec_t v;
    v.rst = r; v.enq = e; v.data = d; v.rdy = rd;
    v.exp_v = ev; v.exp_d = ed; v.exp_cnt = ec; v.exp_full = ef;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, then sample mid-cycle.
  task automatic cycle(input logic r, input logic e, input logic [3:0] d, input logic rd);
    rst = r; enq = e; enqData = d; deqReady = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_1_to_6();
    add(0, 1, 4'h1, 0, 0, 4'h0, 4'd1, 0);
    add(0, 1, 4'h2, 0, 0, 4'h0, 4'd2, 0);
    add(0, 1, 4'h3, 0, 1, 4'h1, 4'd3, 0);
    add(0, 1, 4'h4, 0, 1, 4'h1, 4'd4, 0);
    add(0, 1, 4'h5, 0, 1, 4'h1, 4'd5, 0);
    add(0, 1, 4'h6, 0, 1, 4'h1, 4'd6, 1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; enq = 1'b0; enqData = 4'h0; deqReady = 1'b0;

    // reset
    add(1, 0, 4'h0, 0, 0, 4'h0, 4'd0, 0);
    // single push: visible two edges after the push edge
    add(0, 1, 4'h3, 0, 0, 4'h0, 4'd1, 0);
    add(0, 0, 4'h0, 0, 0, 4'h0, 4'd1, 0);
    add(0, 0, 4'h0, 0, 1, 4'h3, 4'd1, 0);
    add(0, 0, 4'h0, 1, 0, 4'h0, 4'd0, 0);
    // fill to capacity, drop the 7th push, then drain back-to-back
    fill_1_to_6();
    add(0, 1, 4'h7, 0, 1, 4'h1, 4'd6, 1);
    add(0, 0, 4'h0, 1, 1, 4'h2, 4'd5, 0);
    add(0, 0, 4'h0, 1, 1, 4'h3, 4'd4, 0);
    add(0, 0, 4'h0, 1, 1, 4'h4, 4'd3, 0);
    add(0, 0, 4'h0, 1, 1, 4'h5, 4'd2, 0);
    add(0, 0, 4'h0, 1, 1, 4'h6, 4'd1, 0);
    add(0, 0, 4'h0, 1, 0, 4'h0, 4'd0, 0);
    add(0, 0, 4'h0, 0, 0, 4'h0, 4'd0, 0);
    // full with simultaneous push and pop: push dropped, retried next cycle
    fill_1_to_6();
    add(0, 1, 4'hA, 1, 1, 4'h2, 4'd5, 0);
    add(0, 1, 4'hA, 0, 1, 4'h2, 4'd6, 1);
    add(0, 0, 4'h0, 1, 1, 4'h3, 4'd5, 0);
    add(0, 0, 4'h0, 1, 1, 4'h4, 4'd4, 0);
    add(0, 0, 4'h0, 1, 1, 4'h5, 4'd3, 0);
    add(0, 0, 4'h0, 1, 1, 4'h6, 4'd2, 0);
    add(0, 0, 4'h0, 1, 1, 4'hA, 4'd1, 0);
    add(0, 0, 4'h0, 1, 0, 4'h0, 4'd0, 0);
    // reset while a RAM read is in flight
    add(0, 1, 4'h1, 0, 0, 4'h0, 4'd1, 0);
    add(0, 1, 4'h2, 0, 0, 4'h0, 4'd2, 0);
    add(0, 1, 4'h3, 0, 1, 4'h1, 4'd3, 0);
    add(1, 0, 4'h0, 0, 0, 4'h0, 4'd0, 0);
    add(0, 1, 4'h9, 0, 0, 4'h0, 4'd1, 0);
    add(0, 0, 4'h0, 0, 0, 4'h0, 4'd1, 0);
    add(0, 0, 4'h0, 0, 1, 4'h9, 4'd1, 0);
    add(0, 0, 4'h0, 1, 0, 4'h0, 4'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].enq, vecs[i].data, vecs[i].rdy);
      chk($sformatf("v%0d.deqValid", i), {31'd0, deqValid}, {31'd0, vecs[i].exp_v});
      chk($sformatf("v%0d.count", i), {28'd0, count}, {28'd0, vecs[i].exp_cnt});
      chk($sformatf("v%0d.full", i), {31'd0, full}, {31'd0, vecs[i].exp_full});
      if (vecs[i].exp_v) begin
        chk($sformatf("v%0d.deqData", i), {28'd0, deqData}, {28'd0, vecs[i].exp_d});
      end
    end

    // Streaming push+pop every cycle across four pointer wraps. Steady state holds the
    // freshly written RAM word, one word in flight and the head: count = 3.
    cycle(1, 0, 4'h0, 0);
    for (int k = 0; k < 20; k++) begin
      logic [4:0] kk;
      logic [4:0] km2;
      kk  = 5'(k);
      km2 = 5'(k - 2);
      cycle(0, 1, kk[3:0], 1);
      if (k < 2) begin
        chk($sformatf("stream%0d.deqValid", k), {31'd0, deqValid}, 32'd0);
      end else begin
        chk($sformatf("stream%0d.deqValid", k), {31'd0, deqValid}, 32'd1);
        chk($sformatf("stream%0d.deqData", k), {28'd0, deqData}, {28'd0, km2[3:0]});
        chk($sformatf("stream%0d.count", k), {28'd0, count}, 32'd3);
      end
    end
    cycle(0, 0, 4'h0, 1);
    chk("stream_tail0.deqData", {28'd0, deqData}, 32'h2);
    cycle(0, 0, 4'h0, 1);
    chk("stream_tail1.deqData", {28'd0, deqData}, 32'h3);
    cycle(0, 0, 4'h0, 1);
    chk("stream_tail2.deqValid", {31'd0, deqValid}, 32'd0);

    // Error flag: pop on empty, then normal traffic, then reset clears it.
    cycle(1, 0, 4'h0, 0);
    chk("err.after_reset", {31'd0, error}, 32'd0);
    cycle(0, 0, 4'h0, 1);
    chk("err.pop_empty", {31'd0, error}, {31'd0, EXP_ERR});
    cycle(0, 1, 4'h5, 0);
    cycle(0, 0, 4'h0, 0);
    cycle(0, 0, 4'h0, 0);
    chk("err.traffic.deqData", {28'd0, deqData}, 32'h5);
    chk("err.traffic.hold", {31'd0, error}, {31'd0, EXP_ERR});
    cycle(0, 0, 4'h0, 1);
    chk("err.after_pop", {31'd0, error}, {31'd0, EXP_ERR});
    cycle(1, 0, 4'h0, 0);
    chk("err.cleared", {31'd0, error}, 32'd0);
    cycle(0, 0, 4'h0, 0);
    chk("err.idle", {31'd0, error}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
